// File: rtl/playcity_pkg.sv
// Shared encodings for the PlayCity bus initiator: op codes, bus address map,
// sequencer/T-state enums and the latched request record.
package playcity_pkg;

  typedef enum logic [2:0] {
    OP_AY_WR    = 3'd0,
    OP_CTC_WR   = 3'd1,
    OP_CTC_RD   = 3'd2,
    OP_INTA     = 3'd3,
    OP_SOFT_RST = 3'd4
  } pc_op_e;

  localparam logic [7:0]  PC_AY_LATCH_HI = 8'hF9;
  localparam logic [7:0]  PC_AY_DATA_HI  = 8'hF8;
  localparam logic [3:0]  PC_LO_BASE     = 4'h8;
  localparam logic [15:0] PC_CTC_BASE    = 16'hF880;
  localparam logic [15:0] PC_SOFT_RST    = 16'hF8FF;

  typedef enum logic [2:0] {SQ_IDLE, SQ_CYC_A, SQ_GAP, SQ_CYC_B, SQ_RESP} seq_state_e;
  typedef enum logic [2:0] {T_IDLE, T_1, T_2, T_W, T_3} tstate_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] chan;
    logic [3:0] rg;
    logic [7:0] data;
  } pc_req_t;

  // Ops 5-7 and an AY write addressed to neither PSG produce no bus cycle.
  function automatic logic pc_is_nop(input logic [2:0] op, input logic [1:0] chan);
    return (op > 3'd4) || ((op == OP_AY_WR) && (chan == 2'b00));
  endfunction

endpackage

// File: rtl/playcity_io_cycle.sv
// One Z80 I/O or interrupt-acknowledge bus cycle: T1, T2, TW x WAIT_STATES, T3.
// Every state and output change is qualified by phi_en; done is a one-clock strobe leaving T3.
module playcity_io_cycle
  import playcity_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_phi_en,
  input  logic        i_start,
  input  logic        i_is_read,
  input  logic        i_is_inta,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_bus_din,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dout,
  output logic        o_iorq_n,
  output logic        o_m1_n,
  output logic        o_rd_n,
  output logic        o_wr_n,
  output logic        o_done,
  output logic [7:0]  o_rdata
);

  localparam logic [1:0] LAST_W = 2'(WAIT_STATES - 1);

  tstate_e     r_state;
  logic [1:0]  r_wcnt;
  logic        r_read, r_inta;
  logic [15:0] r_addr;
  logic [7:0]  r_dout, r_rdata;
  logic        r_iorq_n, r_m1_n, r_rd_n, r_wr_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= T_IDLE;
      r_wcnt   <= '0;
      r_read   <= 1'b0;
      r_inta   <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_rdata  <= '0;
      r_iorq_n <= 1'b1;
      r_m1_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
    end else if (i_phi_en) begin
      unique case (r_state)
        T_IDLE: if (i_start) begin
          r_state <= T_1;
          r_addr  <= i_addr;
          if (!i_is_read && !i_is_inta) r_dout <= i_data;
          r_read  <= i_is_read;
          r_inta  <= i_is_inta;
          r_m1_n  <= ~i_is_inta;
        end
        // Acknowledge keeps IORQ off until the wait states; RD/WR never move for it.
        T_1: begin
          r_state  <= T_2;
          r_wcnt   <= '0;
          r_iorq_n <= r_inta;
          r_rd_n   <= ~r_read;
          r_wr_n   <= r_read | r_inta;
        end
        T_2: begin
          r_state  <= T_W;
          r_iorq_n <= 1'b0;
        end
        T_W: if (r_wcnt == LAST_W) begin
          r_state  <= T_3;
          r_iorq_n <= 1'b1;
          r_m1_n   <= 1'b1;
          r_rd_n   <= 1'b1;
          r_wr_n   <= 1'b1;
          if (r_read || r_inta) r_rdata <= i_bus_din;
        end else begin
          r_wcnt <= r_wcnt + 2'd1;
        end
        T_3:     r_state <= T_IDLE;
        default: r_state <= T_IDLE;
      endcase
    end
  end

  assign o_done   = i_phi_en && (r_state == T_3);
  assign o_addr   = r_addr;
  assign o_dout   = r_dout;
  assign o_rdata  = r_rdata;
  assign o_iorq_n = r_iorq_n;
  assign o_m1_n   = r_m1_n;
  assign o_rd_n   = r_rd_n;
  assign o_wr_n   = r_wr_n;

endmodule

// File: rtl/playcity_bus_master.sv
// PlayCity bus initiator: sequences request ops into one or two I/O cycles
// (AY writes are latch-then-data) and returns read/vector data as a one-clock response.
module playcity_bus_master
  import playcity_pkg::*;
#(
  parameter int WAIT_STATES = 1,  // 1..3
  parameter int IO_GAP      = 1   // >=1; the first gap T-state is the cycle's own idle state
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        phi_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_chan,
  input  logic [3:0]  req_reg,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  input  logic [7:0]  bus_din,
  output logic        iorq_n,
  output logic        m1_n,
  output logic        rd_n,
  output logic        wr_n
);

  seq_state_e r_state;
  pc_req_t    r_req;
  logic [7:0] r_gap;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;

  logic        w_start, w_done, w_rd_op, w_inta_op;
  logic [15:0] w_addr;
  logic [7:0]  w_data, w_rdata, w_lo;

  assign req_ready = (r_state == SQ_IDLE);
  assign w_rd_op   = (r_req.op == OP_CTC_RD);
  assign w_inta_op = (r_req.op == OP_INTA);
  assign w_start   = (r_state == SQ_CYC_A) || (r_state == SQ_CYC_B);
  assign w_lo      = {PC_LO_BASE, r_req.chan, 2'b00};

  always_comb begin
    w_addr = PC_CTC_BASE | {14'd0, r_req.chan};
    w_data = r_req.data;
    case (r_req.op)
      OP_AY_WR: begin
        // GAP already selects cycle B so its address is ready when T1 starts.
        if (r_state == SQ_CYC_A) begin
          w_addr = {PC_AY_LATCH_HI, w_lo};
          w_data = {4'h0, r_req.rg};
        end else begin
          w_addr = {PC_AY_DATA_HI, w_lo};
        end
      end
      OP_SOFT_RST: w_addr = PC_SOFT_RST;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SQ_IDLE;
      r_req       <= '0;
      r_gap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        SQ_IDLE: if (req_valid) begin
          r_req   <= '{op: req_op, chan: req_chan, rg: req_reg, data: req_data};
          r_state <= pc_is_nop(req_op, req_chan) ? SQ_RESP : SQ_CYC_A;
        end
        SQ_CYC_A: if (w_done) begin
          if (r_req.op == OP_AY_WR) begin
            if (IO_GAP > 1) begin
              r_state <= SQ_GAP;
              r_gap   <= 8'(IO_GAP - 2);
            end else begin
              r_state <= SQ_CYC_B;
            end
          end else if (w_rd_op || w_inta_op) begin
            r_state     <= SQ_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
          end else begin
            r_state <= SQ_IDLE;
          end
        end
        SQ_GAP: if (phi_en) begin
          if (r_gap == 8'd0) r_state <= SQ_CYC_B;
          else               r_gap   <= r_gap - 8'd1;
        end
        SQ_CYC_B: if (w_done) r_state <= SQ_IDLE;
        SQ_RESP:  r_state <= SQ_IDLE;
        default:  r_state <= SQ_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  playcity_io_cycle #(.WAIT_STATES(WAIT_STATES)) u_cyc (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_phi_en  (phi_en),
    .i_start   (w_start),
    .i_is_read (w_rd_op),
    .i_is_inta (w_inta_op),
    .i_addr    (w_addr),
    .i_data    (w_data),
    .i_bus_din (bus_din),
    .o_addr    (addr),
    .o_dout    (dout),
    .o_iorq_n  (iorq_n),
    .o_m1_n    (m1_n),
    .o_rd_n    (rd_n),
    .o_wr_n    (wr_n),
    .o_done    (w_done),
    .o_rdata   (w_rdata)
  );

endmodule

// File: tb/tb_playcity_bus_master.sv
// Directed bench for playcity_bus_master: a vector table of ops with hand-computed
// bus traces, plus reset-state, mid-cycle reset and phi_en stall sequences.
`timescale 1ns/1ps
module tb_playcity_bus_master;

  logic        clock, reset_n, phi_en, req_valid, req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_chan;
  logic [3:0]  req_reg;
  logic [7:0]  req_data, rsp_data, dout, bus_din;
  logic        rsp_valid, iorq_n, m1_n, rd_n, wr_n;
  logic [15:0] addr;

  int checks = 0;
  int errors = 0;
  bit stall  = 1'b0;
  int pcnt   = 0;

  playcity_bus_master #(.WAIT_STATES(1), .IO_GAP(1)) dut (
    .clock(clock), .reset_n(reset_n), .phi_en(phi_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_chan(req_chan), .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .addr(addr), .dout(dout),
    .bus_din(bus_din), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // phi_en: one clock in four, updated well after the edge so negedge samples see the value the next edge uses.
  initial begin
    phi_en = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      pcnt   = (pcnt + 1) % 4;
      phi_en = (pcnt == 0) && !stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  chan;
    logic [3:0]  rg;
    logic [7:0]  data, din;
    int          ncyc;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
    bit          ca, cd;
    int          wr, rd, io, m1, nrsp;
    logic [7:0]  rsp;
    int          tst;   // T-states accept->idle, or -1 for a NOP (ready low exactly 1 clk)
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] ch, input logic [3:0] rg,
                              input logic [7:0] dt, input logic [7:0] din, input int ncyc,
                              input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1, input bit ca, input bit cd,
                              input int wr, input int rd, input int io, input int m1,
                              input int nrsp, input logic [7:0] rsp, input int tst);
    vec_t v;
    v.op = op; v.chan = ch; v.rg = rg; v.data = dt; v.din = din; v.ncyc = ncyc;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.ca = ca; v.cd = cd;
    v.wr = wr; v.rd = rd; v.io = io; v.m1 = m1; v.nrsp = nrsp; v.rsp = rsp; v.tst = tst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    logic [15:0] ca[2];
    logic [7:0]  cd[2];
    int ncyc = 0, nwr = 0, nrd = 0, nio = 0, nm1 = 0, nrsp = 0, nphi = 0, rdylow = 0;
    bit prev_any = 1'b0, any, fin = 1'b0;
    ca[0] = 'x; ca[1] = 'x; cd[0] = 'x; cd[1] = 'x;
    @(negedge clock);
    req_op = v.op; req_chan = v.chan; req_reg = v.rg; req_data = v.data; bus_din = v.din;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (req_ready) begin fin = 1'b1; break; end
      rdylow++;
      if (phi_en) nphi++;
      any = !iorq_n || !m1_n || !rd_n || !wr_n;
      if (any && !prev_any) begin
        if (ncyc < 2) begin ca[ncyc] = addr; cd[ncyc] = dout; end
        ncyc++;
      end
      prev_any = any;
      if (!wr_n) nwr++;
      if (!rd_n) nrd++;
      if (!iorq_n) nio++;
      if (!m1_n) nm1++;
      if (rsp_valid) nrsp++;
    end
    chk($sformatf("v%0d finished", idx), 32'(fin), 32'd1);
    chk($sformatf("v%0d cycles", idx), ncyc, v.ncyc);
    if (v.ncyc >= 1 && v.ca) chk($sformatf("v%0d addr0", idx), 32'(ca[0]), 32'(v.a0));
    if (v.ncyc >= 1 && v.cd) chk($sformatf("v%0d dout0", idx), 32'(cd[0]), 32'(v.d0));
    if (v.ncyc == 2) begin
      chk($sformatf("v%0d addr1", idx), 32'(ca[1]), 32'(v.a1));
      chk($sformatf("v%0d dout1", idx), 32'(cd[1]), 32'(v.d1));
    end
    chk($sformatf("v%0d wr_clks", idx), nwr, v.wr);
    chk($sformatf("v%0d rd_clks", idx), nrd, v.rd);
    chk($sformatf("v%0d iorq_clks", idx), nio, v.io);
    chk($sformatf("v%0d m1_clks", idx), nm1, v.m1);
    chk($sformatf("v%0d rsp_pulses", idx), nrsp, v.nrsp);
    chk($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.rsp));
    if (v.tst < 0) chk($sformatf("v%0d nop_ready_low", idx), rdylow, 1);
    else           chk($sformatf("v%0d tstates", idx), nphi - 1, v.tst);
  endtask

  vec_t vec[12];

  initial begin
    logic [27:0] snap;
    int diff, nrsp, any_cnt;
    bit seen;

    vec[0]  = mk(3'd0, 2'd1, 4'h7, 8'h38, 8'h00, 2, 16'hF984, 8'h07, 16'hF884, 8'h38, 1, 1, 16, 0, 16, 0, 0, 8'h00, 9);
    vec[1]  = mk(3'd0, 2'd3, 4'h0, 8'hFF, 8'h00, 2, 16'hF98C, 8'h00, 16'hF88C, 8'hFF, 1, 1, 16, 0, 16, 0, 0, 8'h00, 9);
    vec[2]  = mk(3'd0, 2'd2, 4'hD, 8'h5E, 8'h00, 2, 16'hF988, 8'h0D, 16'hF888, 8'h5E, 1, 1, 16, 0, 16, 0, 0, 8'h00, 9);
    vec[3]  = mk(3'd1, 2'd2, 4'h0, 8'h47, 8'h00, 1, 16'hF882, 8'h47, 16'h0, 8'h0, 1, 1, 8, 0, 8, 0, 0, 8'h00, 4);
    vec[4]  = mk(3'd2, 2'd2, 4'h0, 8'h00, 8'h5A, 1, 16'hF882, 8'h00, 16'h0, 8'h0, 1, 0, 0, 8, 8, 0, 1, 8'h5A, 4);
    vec[5]  = mk(3'd3, 2'd0, 4'h0, 8'h00, 8'h10, 1, 16'h0,    8'h00, 16'h0, 8'h0, 0, 0, 0, 0, 4, 12, 1, 8'h10, 4);
    vec[6]  = mk(3'd4, 2'd0, 4'h0, 8'hA5, 8'h00, 1, 16'hF8FF, 8'hA5, 16'h0, 8'h0, 1, 1, 8, 0, 8, 0, 0, 8'h10, 4);
    vec[7]  = mk(3'd1, 2'd3, 4'h0, 8'h03, 8'h00, 1, 16'hF883, 8'h03, 16'h0, 8'h0, 1, 1, 8, 0, 8, 0, 0, 8'h10, 4);
    vec[8]  = mk(3'd2, 2'd0, 4'h0, 8'h00, 8'hC3, 1, 16'hF880, 8'h00, 16'h0, 8'h0, 1, 0, 0, 8, 8, 0, 1, 8'hC3, 4);
    vec[9]  = mk(3'd0, 2'd0, 4'h5, 8'h11, 8'h00, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0, 0, 0, 0, 0, 0, 0, 8'hC3, -1);
    vec[10] = mk(3'd5, 2'd1, 4'h1, 8'h22, 8'h00, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0, 0, 0, 0, 0, 0, 0, 8'hC3, -1);
    vec[11] = mk(3'd7, 2'd3, 4'hF, 8'h33, 8'h00, 0, 16'h0, 8'h0, 16'h0, 8'h0, 0, 0, 0, 0, 0, 0, 0, 8'hC3, -1);

    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_chan = '0; req_reg = '0;
    req_data = '0; bus_din = '0;
    repeat (3) @(negedge clock);
    chk("rst addr", 32'(addr), 32'h0);
    chk("rst dout", 32'(dout), 32'h0);
    chk("rst strobes", 32'({iorq_n, m1_n, rd_n, wr_n}), 32'hF);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_data", 32'(rsp_data), 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'h1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 12; i++) do_op(i, vec[i]);

    // Read stalled by phi_en held low mid-TW while a NOP (op 6) waits at the port.
    @(negedge clock);
    req_op = 3'd2; req_chan = 2'd1; bus_din = 8'h77; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin @(negedge clock); seen = !rd_n; end
    chk("stall reach T2", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clock); seen = phi_en; end
    @(posedge clock);
    #1 stall = 1'b1; req_op = 3'd6; req_valid = 1'b1;
    @(negedge clock);
    snap = {addr, dout, iorq_n, m1_n, rd_n, wr_n};
    chk("stall strobes in TW", 32'({iorq_n, m1_n, rd_n, wr_n}), 32'h5);
    diff = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if ({addr, dout, iorq_n, m1_n, rd_n, wr_n} !== snap || req_ready) diff++;
    end
    chk("stall outputs frozen", diff, 0);
    @(posedge clock);
    #1 stall = 1'b0; req_valid = 1'b0;
    nrsp = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (rsp_valid) nrsp++;
      seen = req_ready;
    end
    chk("stall read done", 32'(seen), 32'd1);
    chk("stall rsp pulses", nrsp, 1);
    chk("stall rsp_data", 32'(rsp_data), 32'h77);

    // Reset during T2 of AY cycle A: strobes release asynchronously, no cycle B follows.
    @(negedge clock);
    req_op = 3'd0; req_chan = 2'd1; req_reg = 4'h2; req_data = 8'h99; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin @(negedge clock); seen = !wr_n; end
    chk("midrst reach T2", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst strobes async", 32'({iorq_n, wr_n}), 32'h3);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst req_ready", 32'(req_ready), 32'h1);
    chk("midrst addr", 32'(addr), 32'h0);
    any_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (!iorq_n || !m1_n || !rd_n || !wr_n) any_cnt++;
    end
    chk("midrst no cycle B", any_cnt, 0);
    chk("midrst rsp_data", 32'(rsp_data), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
